// File: rtl/packet_injector.sv
// Per-node traffic source: LFSR-driven packet generation into a small FIFO with valid/ready output.
// Optional statistics counters are built when PACKET_INJECTOR_STATS_EN is defined.
module packet_injector #(
    parameter int unsigned MAX_CYCLE_WIDTH = 5,
    parameter int unsigned NODE_ID_WIDTH   = 4,
    parameter int unsigned NODE_ID         = 0,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [8:0]  INJECTION_RATE  = 9'd128,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [1:0]                                   state,
    input  logic [MAX_CYCLE_WIDTH-1:0]                   current_cycle,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [2*NODE_ID_WIDTH+MAX_CYCLE_WIDTH-1:0]   out_data,
    output logic                                         drained,
    output logic [15:0]                                  injected_count,
    output logic [15:0]                                  dropped_count
);

    localparam int unsigned PKT_W = 2 * NODE_ID_WIDTH + MAX_CYCLE_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0]  ST_RUN    = 2'b01;
    localparam logic [1:0]  ST_DRAIN  = 2'b10;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0]            r_lfsr;
    logic [PKT_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [15:0]            w_lfsr_next;
    logic                   w_gen;
    logic [NODE_ID_WIDTH-1:0] w_dst_raw;
    logic [NODE_ID_WIDTH-1:0] w_dst;
    logic [PKT_W-1:0]       w_pkt;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push;

    // Galois step and injection decision, both taken from the pre-advance LFSR value
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    assign w_gen       = (state == ST_RUN) && ({1'b0, r_lfsr[15:8]} < INJECTION_RATE);

    // A destination equal to our own address is nudged to a neighbour
    assign w_dst_raw = r_lfsr[NODE_ID_WIDTH-1:0];
    assign w_dst     = (w_dst_raw == NODE_ID_WIDTH'(NODE_ID)) ?
                       (w_dst_raw ^ NODE_ID_WIDTH'(1)) : w_dst_raw;
    assign w_pkt     = {NODE_ID_WIDTH'(NODE_ID), w_dst, current_cycle};

    assign w_pop  = (r_count != '0) && out_ready;
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push = w_gen && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pkt;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign drained   = (state == ST_DRAIN) && (r_count == '0);

`ifdef PACKET_INJECTOR_STATS_EN
    logic        w_drop;
    logic [15:0] r_injected;
    logic [15:0] r_dropped;

    assign w_drop = w_gen && !w_push;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_injected <= 16'd0;
            r_dropped  <= 16'd0;
        end else begin
            if (w_push && (r_injected != 16'hFFFF)) begin
                r_injected <= r_injected + 16'd1;
            end
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    assign injected_count = r_injected;
    assign dropped_count  = r_dropped;
`else
    assign injected_count = 16'd0;
    assign dropped_count  = 16'd0;
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Scoreboard bench for packet_injector: three instances (rates 256, 0, 128) share one stimulus stream.
module tb_packet_injector;

    localparam int unsigned CW    = 5;
    localparam int unsigned NW    = 4;
    localparam int unsigned PW    = 2 * NW + CW;
    localparam int unsigned N     = 3;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef PACKET_INJECTOR_STATS_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STAT_MASK = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    state;
    logic [CW-1:0] cc;
    logic          out_ready;

    logic          ov [N];
    logic [PW-1:0] od [N];
    logic          dr [N];
    logic [15:0]   ic [N];
    logic [15:0]   dc [N];

    always #5 clk = ~clk;

    packet_injector #(.NODE_ID(0), .INJECTION_RATE(9'd256)) u_r256 (
        .clk(clk), .reset_n(reset_n), .state(state), .current_cycle(cc),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .drained(dr[0]),
        .injected_count(ic[0]), .dropped_count(dc[0]));

    packet_injector #(.NODE_ID(3), .INJECTION_RATE(9'd0)) u_r0 (
        .clk(clk), .reset_n(reset_n), .state(state), .current_cycle(cc),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .drained(dr[1]),
        .injected_count(ic[1]), .dropped_count(dc[1]));

    packet_injector #(.NODE_ID(5), .INJECTION_RATE(9'd128)) u_r128 (
        .clk(clk), .reset_n(reset_n), .state(state), .current_cycle(cc),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .drained(dr[2]),
        .injected_count(ic[2]), .dropped_count(dc[2]));

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [15:0]   m_lfsr [N];
    int            m_cnt  [N];
    int            m_inj  [N];
    int            m_drop [N];
    logic [PW-1:0] exp_q  [N][$];

    int            pop_cnt [N];
    logic [NW-1:0] dst_log [$];
    logic [CW-1:0] ts_log  [$];
    logic [NW-1:0] ref_dst [8];

    function automatic int rate_of(input int i);
        case (i)
            0:       return 256;
            1:       return 0;
            default: return 128;
        endcase
    endfunction

    function automatic logic [NW-1:0] node_of(input int i);
        case (i)
            0:       return 4'd0;
            1:       return 4'd3;
            default: return 4'd5;
        endcase
    endfunction

    function automatic logic [31:0] stat(input int v);
        return 32'(v) & STAT_MASK;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Model: queue occupancy + plain arithmetic on the injection rules
    always @(posedge clk) begin
        bit            pop, gen, push;
        logic [NW-1:0] d;
        for (int i = 0; i < N; i++) begin
            if (!reset_n) begin
                m_lfsr[i] = SEED;
                m_cnt[i]  = 0;
                m_inj[i]  = 0;
                m_drop[i] = 0;
                exp_q[i].delete();
            end else begin
                pop  = (m_cnt[i] > 0) && out_ready;
                gen  = (state == 2'b01) && (int'(m_lfsr[i][15:8]) < rate_of(i));
                push = gen && ((m_cnt[i] < DEPTH) || pop);
                if (pop) m_cnt[i]--;
                if (push) begin
                    d = m_lfsr[i][NW-1:0];
                    if (d == node_of(i)) d = d ^ 4'd1;
                    exp_q[i].push_back({node_of(i), d, cc});
                    m_cnt[i]++;
                    if (m_inj[i] < 65535) m_inj[i]++;
                end else if (gen) begin
                    if (m_drop[i] < 65535) m_drop[i]++;
                end
                m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 16'hB400 : 16'h0000);
            end
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on each handshake
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                chk("out_valid", i, 32'(ov[i]), 32'(m_cnt[i] != 0));
                chk("drained", i, 32'(dr[i]), 32'((state == 2'b10) && (m_cnt[i] == 0)));
                chk("injected_count", i, 32'(ic[i]), stat(m_inj[i]));
                chk("dropped_count", i, 32'(dc[i]), stat(m_drop[i]));
                if (reset_n && ov[i] && out_ready) begin
                    if (exp_q[i].size() == 0) begin
                        chk("unexpected_pop", i, 32'(1), 32'(0));
                    end else begin
                        e = exp_q[i].pop_front();
                        chk("out_data", i, 32'(od[i]), 32'(e));
                        chk("dst_ne_node", i, 32'(od[i][CW +: NW] != node_of(i)), 32'(1));
                    end
                    pop_cnt[i]++;
                    if (i == 0) begin
                        dst_log.push_back(od[0][CW +: NW]);
                        ts_log.push_back(od[0][CW-1:0]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        tick(n);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_lfsr[i] = SEED; m_cnt[i] = 0; m_inj[i] = 0; m_drop[i] = 0; pop_cnt[i] = 0;
        end
        reset_n = 1'b0; state = 2'b01; cc = '0; out_ready = 1'b0;

        // Reset held two cycles with state=RUN
        @(posedge clk); #1;
        mon_en = 1'b1;
        tick(1);
        chk("rst_valid", 0, 32'(ov[0]), 0);
        chk("rst_inj", 0, 32'(ic[0]), 0);
        chk("rst_drop", 0, 32'(dc[0]), 0);
        reset_n = 1'b1;
        #1 chk("release_valid", 0, 32'(ov[0]), 0);

        // Injection at full rate with ready high, timestamps 3..12
        out_ready = 1'b1;
        pop_cnt[0] = 0; dst_log.delete(); ts_log.delete();
        for (int k = 0; k < 10; k++) begin
            cc = CW'(3 + k);
            tick(1);
        end
        state = 2'b00;
        tick(1);
        chk("inj_pops", 0, 32'(pop_cnt[0]), 10);
        chk("inj_count", 0, 32'(ic[0]), stat(10));
        chk("inj_drop", 0, 32'(dc[0]), 0);
        for (int k = 0; k < 10; k++) chk("inj_ts", k, 32'(ts_log[k]), 32'(3 + k));
        for (int k = 0; k < 8; k++) ref_dst[k] = dst_log[k];

        // Backpressure, timestamps crossing the counter wrap
        state = 2'b00; do_reset(1);
        state = 2'b01; out_ready = 1'b0; cc = 5'd28;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("bp_valid", 0, 32'(ov[0]), 1);
            chk("bp_hold_ts", 0, 32'(od[0][CW-1:0]), 28);
            cc = cc + 5'd1;
        end
        state = 2'b00;
        chk("bp_inj", 0, 32'(ic[0]), stat(4));
        chk("bp_drop", 0, 32'(dc[0]), stat(6));

        // Zero rate with random ready
        do_reset(1);
        state = 2'b01;
        for (int k = 0; k < 32; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            cc = cc + 5'd1;
            tick(1);
            chk("zero_valid", 1, 32'(ov[1]), 0);
        end
        chk("zero_inj", 1, 32'(ic[1]), 0);
        chk("zero_drop", 1, 32'(dc[1]), 0);

        // Drain
        state = 2'b00; out_ready = 1'b0; do_reset(1);
        state = 2'b01;
        tick(4);
        state = 2'b10; out_ready = 1'b1; pop_cnt[0] = 0;
        #1 chk("drain_start", 0, 32'(dr[0]), 0);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk("drain_flag", k, 32'(dr[0]), 32'(k == 4));
        end
        tick(2);
        chk("drain_pops", 0, 32'(pop_cnt[0]), 4);
        chk("drain_inj", 0, 32'(ic[0]), stat(4));
        state = 2'b01;
        #1 chk("drain_to_run", 0, 32'(dr[0]), 0);

        // Full FIFO with simultaneous pop, then mid-run reset
        state = 2'b00; out_ready = 1'b0; do_reset(1);
        state = 2'b01;
        tick(4);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("full_pop_valid", k, 32'(ov[0]), 1);
            chk("full_pop_drop", k, 32'(dc[0]), 0);
            chk("full_pop_inj", k, 32'(ic[0]), stat(4 + k));
        end
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_valid", 0, 32'(ov[0]), 0);
        chk("mid_rst_inj", 0, 32'(ic[0]), 0);
        chk("mid_rst_drop", 0, 32'(dc[0]), 0);
        reset_n = 1'b1;
        dst_log.delete();
        tick(9);
        state = 2'b00;
        tick(1);
        for (int k = 0; k < 8; k++) chk("lfsr_restart", k, 32'(dst_log[k]), 32'(ref_dst[k]));

        // Randomized phases, ready and occasional resets
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0:             state = 2'b00;
                    1, 2, 3, 4, 5: state = 2'b01;
                    6, 7:          state = 2'b10;
                    default:       state = 2'b11;
                endcase
            end
            out_ready = ($urandom_range(0, 9) < 6);
            reset_n   = ($urandom_range(0, 199) != 0);
            cc = cc + 5'd1;
            tick(1);
        end
        reset_n = 1'b1; state = 2'b10; out_ready = 1'b1;
        tick(8);
        for (int i = 0; i < N; i++) begin
            chk("final_drained", i, 32'(dr[i]), 1);
            chk("final_queue", i, 32'(exp_q[i].size()), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
